seg_scan4: RTL and testbench
============================

Name: seg_scan4

Overview:
- Time-multiplexed 4-digit 7-segment scan controller for the 8255 interface display path.
- Holds a 16-bit display value and cycles through the four digits. Per digit it presents one hex nibble to the existing 4-bit hex-to-segment decoder, drives active-low digit anodes, and inserts an anti-ghosting dead time between digits.
- A load strobe updates the shown value only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; must be >= 4.
- DEAD_CYC, 500: cycles at the start of each slot with all anodes off; 1 <= DEAD_CYC < CLK_DIV.
- CNT_W, 16: prescaler width; CLK_DIV <= 2**CNT_W.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous active-high reset.
- iEN  in  1  scan enable.
- iLOAD  in  1  single-cycle strobe; captures iDATA/iDP.
- iDATA  in  16  value; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- iDP  in  4  decimal point per digit.
- iLZ  in  1  leading-zero suppression enable.
- oDIG  out  4  nibble to the segment decoder.
- oBLANK  out  1  high means segment outputs must be gated off.
- oDP  out  1  decimal point for the current digit.
- oAN  out  4  digit anodes, active-low, at most one low.
- oPEND  out  1  a load is captured and not yet displayed.

Behaviour:
- Reset: one clock (iCLK); reset iRST is asynchronous and active-high.
- Reset values: oAN=4'b1111, oDIG=0, oBLANK=1, oDP=0, oPEND=0, display/pending regs=0, digit index=0, prescaler=0.
- All outputs are registered.
- Prescaler counts 0..CLK_DIV-1 and wraps. The wrap cycle is the slot boundary; the index advances 0->1->2->3->0.
- Frame boundary = slot boundary where index goes 3->0.
- Within a slot with count c:
  - c < DEAD_CYC: oAN=1111.
  - c >= DEAD_CYC: oAN[index]=0, unless the digit is blanked.
- oDIG, oDP and oBLANK change only at the slot start, while the anodes are off. Each anode is low for exactly CLK_DIV-DEAD_CYC cycles per slot.
- Load handshake:
  - iLOAD=1 writes iDATA/iDP into the pending regs and sets oPEND next cycle.
  - A second iLOAD before the frame boundary overwrites pending (last write wins).
  - At a frame boundary with oPEND=1, display regs take pending and oPEND clears.
  - iLOAD on the same cycle as a frame boundary: iDATA/iDP go directly to the display regs; oPEND=0 afterwards.
- Leading-zero suppression (iLZ=1): digit i in {3,2,1} is blanked if display nibbles 3..i are all zero. Digit 0 is never blanked.
- A blanked digit has oBLANK=1, oDP=0 and its anode held high for the whole slot.
- iLZ is sampled at each slot start.
- iEN=0:
  - Next cycle oAN=1111 and oBLANK=1.
  - Prescaler and index are held at 0.
  - Loads are still accepted. While disabled, a pending value transfers to display on the next cycle.
  - On iEN rising, the scan resumes at digit 0, count 0 (dead time first).
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronous). Pending data is lost.
- Counter width: the prescaler compare uses CNT_W bits; no truncation is permitted (elaboration check on the parameters).

Decomposition:
- Package seg_scan_pkg:
  - NUM_DIG=4
  - AN_OFF=4'b1111
  - index type (2-bit)
  - function lz_blank(display, index)
- Sub-module seg_scan_tick: prescaler with parameters CLK_DIV/CNT_W.
  - Inputs: iCLK, iRST, clear.
  - Outputs: count, slot_end pulse.
- The top level instantiates seg_scan_tick and contains the index, load and blanking logic. oDIG/oBLANK connect to the decoder outside this block.

Test Plan (CLK_DIV=8, DEAD_CYC=2):
- Reset release, iEN=1, iLOAD with iDATA=16'h1234 -> after the next frame boundary oDIG sequence is 4,3,2,1. oAN per slot is 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles. oAN never has two zeros.
- iDATA=16'h0005, iLZ=1 -> digits 3,2,1 have oBLANK=1, oAN=1111, oDP=0; digit 0 shows 5. With iLZ=0, all show 0,0,0,5.
- iDATA=16'h0000, iLZ=1 -> only digit 0 is lit, showing 0.
- iLOAD 16'hAAAA mid-frame, then iLOAD 16'hBBBB before the boundary -> oPEND=1 until the boundary, then display is BBBB and AAAA never appears. iLOAD 16'hCCCC exactly on the boundary cycle -> CCCC shown that frame, oPEND stays 0.
- iEN low mid-slot of digit 2 -> next cycle oAN=1111. iEN high -> digit 0 slot starts with 2 dead cycles.
- iRST pulsed while oAN=1011 -> oAN=1111 and oBLANK=1 without a clock edge. oPEND=0 and display=0 after release.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared constants, digit index type and leading-zero blanking
//               helper for the 4-digit 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

   localparam int              NUM_DIG = 4;
   localparam logic [3:0]      AN_OFF  = 4'b1111;

   typedef logic [1:0] dig_idx_t;

   // A digit is blank when it and every digit to its left are zero.
   // Digit 0 always shows, so a value of zero still displays "0".
   function automatic logic lz_blank(input logic [15:0] disp, input dig_idx_t idx);
      logic blank;
      blank = 1'b0;
      case (idx)
         2'd1:    blank = (disp[15:4]  == 12'h000);
         2'd2:    blank = (disp[15:8]  == 8'h00);
         2'd3:    blank = (disp[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
      return blank;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_tick
// Description : Digit-slot prescaler. Counts 0..CLK_DIV-1 and flags the
//               last cycle of each slot. Clear holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_tick #(
   parameter int CLK_DIV = 50000,
   parameter int CNT_W   = 16
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             clear_i,
   output logic [CNT_W-1:0] count_o,
   output logic             slot_end_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: hold at zero while cleared, otherwise wrap at the slot end.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_q == LAST_CNT) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Prescaler register.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign slot_end_o = !clear_i && (count_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/seg_scan4.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan4
// Description : Time-multiplexed 4-digit 7-segment scan controller with
//               anti-ghosting dead time, frame-synchronous value loading and
//               leading-zero suppression. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan4
   import seg_scan_pkg::*;
#(
   parameter int CLK_DIV  = 50000,
   parameter int DEAD_CYC = 500,
   parameter int CNT_W    = 16
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iEN,
   input  logic        iLOAD,
   input  logic [15:0] iDATA,
   input  logic [3:0]  iDP,
   input  logic        iLZ,
   output logic [3:0]  oDIG,
   output logic        oBLANK,
   output logic        oDP,
   output logic [3:0]  oAN,
   output logic        oPEND
);

   generate
      if (CLK_DIV < 4 || DEAD_CYC < 1 || DEAD_CYC >= CLK_DIV ||
          longint'(CLK_DIV) > (longint'(1) << CNT_W)) begin : g_param_err
         $error("seg_scan4: illegal CLK_DIV / DEAD_CYC / CNT_W combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);

   logic [CNT_W-1:0] w_count;
   logic             w_slot_end;
   logic             w_frame_end;
   logic             w_blank;
   logic [3:0]       w_nib;

   dig_idx_t    idx_q,       idx_d;
   logic [15:0] disp_q,      disp_d;
   logic [3:0]  disp_dp_q,   disp_dp_d;
   logic [15:0] pend_data_q, pend_data_d;
   logic [3:0]  pend_dp_q,   pend_dp_d;
   logic        pend_q,      pend_d;
   logic        lz_q,        lz_d;
   logic [3:0]  an_q,        an_d;
   logic [3:0]  dig_q,       dig_d;
   logic        blank_q,     blank_d;
   logic        dp_q,        dp_d;

   seg_scan_tick #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_tick (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .clear_i    (!iEN),
      .count_o    (w_count),
      .slot_end_o (w_slot_end)
   );

   assign w_frame_end = w_slot_end && (idx_q == 2'd3);
   assign w_blank     = lz_q && lz_blank(disp_q, idx_q);
   assign w_nib       = disp_q[{idx_q, 2'b00} +: 4];

   // Digit index, leading-zero sample and the pending/display load handshake.
   always_comb begin
      idx_d       = idx_q;
      lz_d        = lz_q;
      disp_d      = disp_q;
      disp_dp_d   = disp_dp_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      pend_d      = pend_q;
      if (!iEN) begin
         // Idle: no frames run, so a pending value is promoted one cycle later.
         idx_d = '0;
         lz_d  = iLZ;
         if (iLOAD) begin
            pend_data_d = iDATA;
            pend_dp_d   = iDP;
            pend_d      = 1'b1;
         end else if (pend_q) begin
            disp_d    = pend_data_q;
            disp_dp_d = pend_dp_q;
            pend_d    = 1'b0;
         end
      end else begin
         if (w_slot_end) begin
            idx_d = idx_q + 1'b1;
            lz_d  = iLZ;
         end
         if (iLOAD && w_frame_end) begin
            // A load landing on the boundary bypasses the pending stage.
            disp_d    = iDATA;
            disp_dp_d = iDP;
            pend_d    = 1'b0;
         end else if (iLOAD) begin
            pend_data_d = iDATA;
            pend_dp_d   = iDP;
            pend_d      = 1'b1;
         end else if (w_frame_end && pend_q) begin
            disp_d    = pend_data_q;
            disp_dp_d = pend_dp_q;
            pend_d    = 1'b0;
         end
      end
   end

   // Output drive: anodes off during dead time, for blanked digits and when idle.
   always_comb begin
      an_d    = AN_OFF;
      dig_d   = dig_q;
      blank_d = 1'b1;
      dp_d    = 1'b0;
      if (iEN) begin
         dig_d   = w_nib;
         blank_d = w_blank;
         dp_d    = disp_dp_q[idx_q] && !w_blank;
         if ((w_count >= DEAD_LIM) && !w_blank) begin
            an_d[idx_q] = 1'b0;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         idx_q       <= '0;
         lz_q        <= 1'b0;
         disp_q      <= '0;
         disp_dp_q   <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_q      <= 1'b0;
         an_q        <= AN_OFF;
         dig_q       <= '0;
         blank_q     <= 1'b1;
         dp_q        <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         lz_q        <= lz_d;
         disp_q      <= disp_d;
         disp_dp_q   <= disp_dp_d;
         pend_data_q <= pend_data_d;
         pend_dp_q   <= pend_dp_d;
         pend_q      <= pend_d;
         an_q        <= an_d;
         dig_q       <= dig_d;
         blank_q     <= blank_d;
         dp_q        <= dp_d;
      end
   end

   assign oAN    = an_q;
   assign oDIG   = dig_q;
   assign oBLANK = blank_q;
   assign oDP    = dp_q;
   assign oPEND  = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan4.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan4
// Description : Directed self-checking bench for seg_scan4 (CLK_DIV=8,
//               DEAD_CYC=2). Outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan4;

   localparam int CLK_DIV  = 8;
   localparam int DEAD_CYC = 2;
   localparam int CNT_W    = 16;
   localparam int FRAME    = 4 * CLK_DIV;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iEN;
   logic        iLOAD;
   logic [15:0] iDATA;
   logic [3:0]  iDP;
   logic        iLZ;
   logic [3:0]  oDIG;
   logic        oBLANK;
   logic        oDP;
   logic [3:0]  oAN;
   logic        oPEND;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model of the display/pending registers.
   logic [15:0] disp_m;
   logic [3:0]  dp_m;
   logic [15:0] pdata_m;
   logic [3:0]  pdp_m;
   logic        pend_m;

   always #5 iCLK = ~iCLK;

   seg_scan4 #(
      .CLK_DIV  (CLK_DIV),
      .DEAD_CYC (DEAD_CYC),
      .CNT_W    (CNT_W)
   ) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iEN    (iEN),
      .iLOAD  (iLOAD),
      .iDATA  (iDATA),
      .iDP    (iDP),
      .iLZ    (iLZ),
      .oDIG   (oDIG),
      .oBLANK (oBLANK),
      .oDP    (oDP),
      .oAN    (oAN),
      .oPEND  (oPEND)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Disable, load a value (promoted while idle), then re-enable at digit 0.
   task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic lz);
      @(negedge iCLK);
      iEN = 1'b0; iLOAD = 1'b1; iDATA = d; iDP = p; iLZ = lz;
      @(negedge iCLK);
      iLOAD = 1'b0;
      check("rs_pend_set", 16'(oPEND), 16'h1);
      @(negedge iCLK);
      check("rs_pend_clr", 16'(oPEND), 16'h0);
      check("rs_an_off", 16'(oAN), 16'hF);
      check("rs_blank", 16'(oBLANK), 16'h1);
      iEN    = 1'b1;
      disp_m = d;
      dp_m   = p;
      pend_m = 1'b0;
   endtask

   // Check one whole frame cycle by cycle, optionally issuing loads at
   // frame-local cycles ja and jb (30 is the boundary cycle).
   task automatic frame(input logic lz, input int ja, input logic [15:0] va,
                        input int jb, input logic [15:0] vb);
      logic [15:0] nd;
      logic [3:0]  ndp;
      logic [3:0]  ean;
      logic        bl;
      logic        edp;
      int          c;
      int          i;
      nd  = disp_m;
      ndp = dp_m;
      for (int j = 0; j < FRAME; j++) begin
         @(negedge iCLK);
         c   = j % CLK_DIV;
         i   = j / CLK_DIV;
         bl  = (i != 0) && lz && ((disp_m >> (4 * i)) == 16'h0);
         ean = 4'hF;
         if (c >= DEAD_CYC && !bl) ean = ~(4'b0001 << i);
         edp = dp_m[i[1:0]] && !bl;
         check("an", 16'(oAN), 16'(ean));
         check("an_onehot", 16'($countones(~oAN) <= 1), 16'h1);
         check("dig", 16'(oDIG), (disp_m >> (4 * i)) & 16'h000F);
         check("blank", 16'(oBLANK), 16'(bl));
         check("dp", 16'(oDP), 16'(edp));
         check("pend", 16'(oPEND), 16'(pend_m));
         iLOAD = 1'b0;
         if (j == ja) begin iLOAD = 1'b1; iDATA = va; iDP = 4'h0; end
         if (j == jb) begin iLOAD = 1'b1; iDATA = vb; iDP = 4'h0; end
         if (j == FRAME - 2) begin
            if (iLOAD) begin
               nd = iDATA; ndp = iDP; pend_m = 1'b0;
            end else if (pend_m) begin
               nd = pdata_m; ndp = pdp_m; pend_m = 1'b0;
            end
         end else if (iLOAD) begin
            pdata_m = iDATA; pdp_m = iDP; pend_m = 1'b1;
         end
      end
      disp_m = nd;
      dp_m   = ndp;
   endtask

   initial begin
      iRST = 1'b1; iEN = 1'b0; iLOAD = 1'b0; iLZ = 1'b0; iDATA = '0; iDP = '0;
      disp_m = '0; dp_m = '0; pdata_m = '0; pdp_m = '0; pend_m = 1'b0;

      // Reset values.
      #12;
      check("rst_an", 16'(oAN), 16'hF);
      check("rst_dig", 16'(oDIG), 16'h0);
      check("rst_blank", 16'(oBLANK), 16'h1);
      check("rst_dp", 16'(oDP), 16'h0);
      check("rst_pend", 16'(oPEND), 16'h0);
      @(negedge iCLK);
      iRST = 1'b0;

      // Load 1234 mid-frame; it appears from the next frame as 4,3,2,1.
      restart(16'h0000, 4'h0, 1'b0);
      frame(1'b0, 10, 16'h1234, -1, 16'h0);
      frame(1'b0, -1, 16'h0, -1, 16'h0);

      // Leading-zero suppression of 0005, all decimal points requested.
      restart(16'h0005, 4'hF, 1'b1);
      frame(1'b1, -1, 16'h0, -1, 16'h0);
      restart(16'h0005, 4'hF, 1'b0);
      frame(1'b0, -1, 16'h0, -1, 16'h0);

      // Zero with suppression: only digit 0 lit.
      restart(16'h0000, 4'h0, 1'b1);
      frame(1'b1, -1, 16'h0, -1, 16'h0);

      // Last write wins; a boundary load goes straight to display.
      restart(16'h0000, 4'h0, 1'b0);
      frame(1'b0, 4, 16'hAAAA, 18, 16'hBBBB);
      frame(1'b0, FRAME - 2, 16'hCCCC, -1, 16'h0);
      frame(1'b0, -1, 16'h0, -1, 16'h0);

      // Disable mid-slot of digit 2, then resume at digit 0 with dead time.
      restart(16'h1234, 4'h0, 1'b0);
      repeat (20) @(negedge iCLK);
      check("en_an_d2", 16'(oAN), 16'hB);
      iEN = 1'b0;
      @(negedge iCLK);
      check("dis_an", 16'(oAN), 16'hF);
      check("dis_blank", 16'(oBLANK), 16'h1);
      @(negedge iCLK);
      iEN = 1'b1;
      frame(1'b0, -1, 16'h0, -1, 16'h0);

      // Asynchronous reset mid-slot with a load pending.
      restart(16'h1234, 4'h0, 1'b0);
      repeat (17) @(negedge iCLK);
      iLOAD = 1'b1; iDATA = 16'h5678;
      @(negedge iCLK);
      iLOAD = 1'b0;
      check("pre_rst_pend", 16'(oPEND), 16'h1);
      repeat (2) @(negedge iCLK);
      check("pre_rst_an", 16'(oAN), 16'hB);
      #2 iRST = 1'b1;
      #1;
      check("arst_an", 16'(oAN), 16'hF);
      check("arst_blank", 16'(oBLANK), 16'h1);
      check("arst_pend", 16'(oPEND), 16'h0);
      @(negedge iCLK);
      iRST   = 1'b0;
      disp_m = '0;
      dp_m   = '0;
      pend_m = 1'b0;
      frame(1'b0, -1, 16'h0, -1, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
